// File: rtl/ysyx_22040127_pkg.sv
// Shared constants and grant encoding for the write-back arbiter and its scoreboard.
package ysyx_22040127_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        GNT_S0 = 1'b0,
        GNT_S1 = 1'b1
    } grant_e;

endpackage

// File: rtl/ysyx_22040127_scoreboard.sv
// Per-register busy bits used by issue for RAW stalls; set from issue, cleared on register file commit.
module ysyx_22040127_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [ADDR_WIDTH-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_any_busy
);

    localparam int NUM = 1 << ADDR_WIDTH;

    logic [NUM-1:0] r_busy;
    logic [NUM-1:0] w_busy_nxt;

    // Set is applied after clear so a newly issued producer survives an older commit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];
    assign o_any_busy = |r_busy;

endmodule

// File: rtl/ysyx_22040127_wb_arbiter.sv
// Round-robin sharing of the register file write port between EXU (s0) and LSU/MDU (s1),
// with a one-cycle output stage, x0 write suppression and the busy scoreboard.
module ysyx_22040127_wb_arbiter #(
    parameter int ADDR_WIDTH = ysyx_22040127_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ysyx_22040127_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  sb_set_en,
    input  logic [ADDR_WIDTH-1:0] sb_set_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  idle
);

    import ysyx_22040127_pkg::*;

    grant_e                  r_last_grant;
    logic                    r_wen;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_any_busy;

    // On contention the source that did not win last time is granted.
    always_comb begin
        w_gnt0 = s0_valid && (!s1_valid || (r_last_grant == GNT_S1));
        w_gnt1 = s1_valid && (!s0_valid || (r_last_grant == GNT_S0));
    end

    assign w_accept = w_gnt0 || w_gnt1;
    assign w_addr   = w_gnt1 ? s1_addr : s0_addr;
    assign w_data   = w_gnt1 ? s1_data : s0_data;
    assign s0_ready = w_gnt0;
    assign s1_ready = w_gnt1;

    // x0 targets still handshake but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_S1;
            r_wen        <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_wen <= w_accept && (w_addr != '0);
            if (w_accept) begin
                r_waddr      <= w_addr;
                r_wdata      <= w_data;
                r_last_grant <= w_gnt1 ? GNT_S1 : GNT_S0;
            end
        end
    end

    ysyx_22040127_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (sb_set_en),
        .i_set_addr (sb_set_addr),
        .i_clr_en   (r_wen),
        .i_clr_addr (r_waddr),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_busy (rs1_busy),
        .o_rs2_busy (rs2_busy),
        .o_any_busy (w_any_busy)
    );

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign idle     = !w_any_busy && !r_wen;

endmodule

// File: tb/tb_ysyx_22040127_wb_arbiter.sv
// Directed bench for the write-back arbiter with a one-deep expected-write scoreboard queue.
module tb_ysyx_22040127_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr;
    logic [63:0] s0_data, s1_data;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        idle;

    typedef struct packed {
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         q[$];
    logic [31:0] m_busy;
    logic        m_last;
    logic        m_g0, m_g1;
    int          n_cmp;
    int          n_err;
    logic [3:0]  pat;

    ysyx_22040127_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .s0_valid    (s0_valid),
        .s0_ready    (s0_ready),
        .s0_addr     (s0_addr),
        .s0_data     (s0_data),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .s1_addr     (s1_addr),
        .s1_data     (s1_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .idle        (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, advance the reference model, then return just after the rising edge.
    task automatic tick();
        wr_t         e;
        wr_t         n;
        logic        g0, g1;
        @(negedge clk);
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL q_empty: observed=0 expected=1 queued write");
            e = '0;
        end else begin
            e = q.pop_front();
        end
        chk("rf_wen", rf_wen, e.wen);
        if (e.wen) begin
            chk("rf_waddr", rf_waddr, e.addr);
            chk("rf_wdata", rf_wdata, e.data);
        end
        g0 = s0_valid && (!s1_valid || m_last);
        g1 = s1_valid && (!s0_valid || !m_last);
        chk("s0_ready", s0_ready, g0);
        chk("s1_ready", s1_ready, g1);
        chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
        chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
        chk("idle", idle, (m_busy == 32'd0) && !e.wen);
        n.addr = g1 ? s1_addr : s0_addr;
        n.data = g1 ? s1_data : s0_data;
        n.wen  = (g0 || g1) && (n.addr != 5'd0);
        q.push_back(n);
        if (e.wen) m_busy[e.addr] = 1'b0;
        if (sb_set_en && sb_set_addr != 5'd0) m_busy[sb_set_addr] = 1'b1;
        m_busy[0] = 1'b0;
        if (g0) m_last = 1'b0;
        if (g1) m_last = 1'b1;
        m_g0 = g0;
        m_g1 = g1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back('0);
        m_busy = '0;
        m_last = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        s0_valid = 0; s1_valid = 0; s0_addr = 0; s1_addr = 0; s0_data = 0; s1_data = 0;
        sb_set_en = 0; sb_set_addr = 0; rs1_addr = 0; rs2_addr = 0;
        m_g0 = 0; m_g1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_idle", idle, 1'b1);
        rst = 1'b0;
        model_reset();

        // Reset while a write sits in the output stage
        s0_valid = 1; s0_addr = 5'd4; s0_data = 64'h4444; sb_set_en = 1; sb_set_addr = 5'd3; rs1_addr = 5'd3;
        tick();
        s0_valid = 0; sb_set_en = 0;
        #1;
        chk("t1_inflight", rf_wen, 1'b1);
        chk("t1_busy_before", rs1_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("t1_rst_wen", rf_wen, 1'b0);
        chk("t1_rst_waddr", rf_waddr, 5'd0);
        chk("t1_rst_wdata", rf_wdata, 64'd0);
        chk("t1_rst_busy", rs1_busy, 1'b0);
        chk("t1_rst_idle", idle, 1'b1);
        rst = 1'b0;
        model_reset();
        s0_valid = 1; s0_addr = 5'd1; s0_data = 64'h1111;
        s1_valid = 1; s1_addr = 5'd2; s1_data = 64'h2222;
        #1;
        chk("t1_first_s0", s0_ready, 1'b1);
        chk("t1_first_s1", s1_ready, 1'b0);
        tick();
        s0_valid = 0;
        tick();
        s1_valid = 0;

        // Single source
        s1_valid = 1; s1_addr = 5'd5; s1_data = 64'hDEAD_BEEF;
        #1;
        chk("t2_ready", s1_ready, 1'b1);
        tick();
        s1_valid = 0;
        chk("t2_wen", rf_wen, 1'b1);
        chk("t2_waddr", rf_waddr, 5'd5);
        chk("t2_wdata", rf_wdata, 64'hDEAD_BEEF);
        tick();
        chk("t2_wen_off", rf_wen, 1'b0);

        // Contention alternates, starting with s0
        pat = 4'b0101;
        s0_valid = 1; s0_addr = 5'd10; s0_data = 64'hA000;
        s1_valid = 1; s1_addr = 5'd11; s1_data = 64'hB000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_s0_ready", s0_ready, pat[i]);
            chk("t3_s1_ready", s1_ready, !pat[i]);
            tick();
            if (m_g0) s0_data = s0_data + 64'd1;
            if (m_g1) s1_data = s1_data + 64'd1;
        end
        s0_valid = 0; s1_valid = 0;
        chk("t3_last_wen", rf_wen, 1'b1);
        chk("t3_last_data", rf_wdata, 64'hB001);
        tick();

        // Busy set by issue, cleared on commit
        sb_set_en = 1; sb_set_addr = 5'd7; rs1_addr = 5'd7;
        tick();
        sb_set_en = 0;
        chk("t4_busy_c1", rs1_busy, 1'b1);
        tick();
        tick();
        s0_valid = 1; s0_addr = 5'd7; s0_data = 64'h7777;
        tick();
        s0_valid = 0;
        chk("t4_wen_c4", rf_wen, 1'b1);
        chk("t4_busy_c4", rs1_busy, 1'b1);
        tick();
        chk("t4_busy_c5", rs1_busy, 1'b0);
        tick();

        // Set and clear of the same register on one edge
        sb_set_en = 1; sb_set_addr = 5'd9;
        tick();
        sb_set_en = 0;
        s1_valid = 1; s1_addr = 5'd9; s1_data = 64'h9999;
        tick();
        s1_valid = 0;
        sb_set_en = 1; sb_set_addr = 5'd9;
        chk("t5_wen", rf_wen, 1'b1);
        chk("t5_waddr", rf_waddr, 5'd9);
        tick();
        sb_set_en = 0; rs2_addr = 5'd9;
        #1;
        chk("t5_still_busy", rs2_busy, 1'b1);
        s1_valid = 1;
        tick();
        s1_valid = 0;
        tick();
        tick();
        chk("t5_idle", idle, 1'b1);

        // x0 guard
        s0_valid = 1; s0_addr = 5'd0; s0_data = 64'h1234;
        #1;
        chk("t6_ready", s0_ready, 1'b1);
        tick();
        s0_valid = 0;
        chk("t6_wen", rf_wen, 1'b0);
        sb_set_en = 1; sb_set_addr = 5'd0; rs1_addr = 5'd0;
        tick();
        sb_set_en = 0;
        chk("t6_rs1_x0", rs1_busy, 1'b0);
        chk("t6_idle", idle, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_wb_arbiter.md
Name: ysyx_22040127_wb_arbiter

Overview:
Write-back controller in front of the 32x64 integer register file. It shares the register file's single write port between two write-back sources, s0 (EXU, single-cycle results) and s1 (LSU/MDU, multi-cycle results), using valid/ready handshakes and round-robin arbitration. It holds a per-register busy scoreboard that the issue stage uses for RAW hazard stalls. It also guarantees that no write ever reaches x0.

Parameters:
ADDR_WIDTH, 5, register index width; the scoreboard has 1<<ADDR_WIDTH entries.
DATA_WIDTH, 64, write data width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
s0_valid  input  1  EXU write-back request.
s0_ready  output  1  EXU request accepted this cycle.
s0_addr  input  ADDR_WIDTH  EXU destination register.
s0_data  input  DATA_WIDTH  EXU result.
s1_valid  input  1  LSU/MDU write-back request.
s1_ready  output  1  LSU/MDU request accepted this cycle.
s1_addr  input  ADDR_WIDTH  LSU/MDU destination register.
s1_data  input  DATA_WIDTH  LSU/MDU result.
sb_set_en  input  1  issue stage marks a destination register busy.
sb_set_addr  input  ADDR_WIDTH  register being marked busy.
rs1_addr  input  ADDR_WIDTH  source register 1 query.
rs2_addr  input  ADDR_WIDTH  source register 2 query.
rs1_busy  output  1  rs1 has a pending write.
rs2_busy  output  1  rs2 has a pending write.
rf_wen  output  1  register file write enable.
rf_waddr  output  ADDR_WIDTH  register file write address.
rf_wdata  output  DATA_WIDTH  register file write data.
idle  output  1  no busy bits set and no write in flight.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All scoreboard bits are 0.
  - last_grant=1, so s0 wins the first conflict.
  - A write held in the output stage is discarded immediately, not committed.
- Arbitration is combinational within the cycle:
  - Only one source valid: that source is granted.
  - Both valid: the source not equal to last_grant is granted.
  - sN_ready = grantN. There is never more than one ready per cycle, and ready is never asserted without the matching valid.
- Accept: a transfer happens when sN_valid && sN_ready in cycle N.
  - On that edge last_grant updates to N, and addr/data are captured into the output stage.
  - A source that is not granted must hold valid, addr and data stable until it is accepted.
- Latency: accept in cycle N gives rf_wen=1 with the captured addr/data in cycle N+1, exactly one cycle. With no accept, rf_wen=0 in the next cycle.
- x0 guard: an accepted request with addr==0 completes its handshake normally but produces rf_wen=0. rf_waddr/rf_wdata are don't-care in that cycle.
- Throughput is one write per cycle, with no bubble between back-to-back accepts.
- Scoreboard update on each edge:
  - Set: sb_set_en && sb_set_addr!=0 sets bit[sb_set_addr].
  - Clear: rf_wen=1 clears bit[rf_waddr]. The clear lands on the same edge the register file commits the data, so the new value is readable from the cycle after the write.
  - Set and clear of the same address on the same edge: set wins (a newer producer was issued).
  - Bit 0 is constant 0.
- rsK_busy = scoreboard[rsK_addr], combinational from the registered state. Address 0 always reads 0.
- idle = (scoreboard==0) && !rf_wen.
- No retirement ordering between s0 and s1 is enforced. The issue stage must not issue a second producer of a register that is already busy; if it does, the first write clears the bit.

Decomposition:
- Shared package ysyx_22040127_pkg holds:
  - localparams for ADDR_WIDTH=5, DATA_WIDTH=64, NUM_REGS=32.
  - Grant encoding: GNT_S0=0, GNT_S1=1.
- Sub-module ysyx_22040127_scoreboard, parameterised by ADDR_WIDTH. It contains:
  - The 32-bit busy vector with its set/clear priority and x0 tie-off.
  - The two read ports.
- The top level holds the round-robin arbiter, the output stage and idle.

Test Plan:
1. Reset: assert rst mid-cycle while an accepted write is in flight -> rf_wen=0 immediately, all busy bits 0, idle=1. After release, s0 and s1 both valid -> s0_ready=1 first.
2. Single source: s1_valid, addr=5, data=0xDEAD_BEEF in cycle 0 -> s1_ready=1 in cycle 0; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 1; rf_wen=0 in cycle 2.
3. Contention: s0 and s1 both valid continuously for 4 cycles -> grants alternate s0,s1,s0,s1. rf_wen is high in cycles 1-4 with the matching data; the stalled source's data is unchanged until its accept.
4. Scoreboard: set x7 in cycle 0 -> rs1_addr=7 gives rs1_busy=1 from cycle 1. s0 accept x7 in cycle 3 -> rf_wen in cycle 4, rs1_busy=0 from cycle 5.
5. Set/clear collision: rf_wen=1 for x9 on the same edge as sb_set_en for x9 -> x9 remains busy.
6. x0 guard: s0 accept with addr=0, data=0x1234 -> s0_ready=1, rf_wen stays 0. sb_set_en with addr 0 -> rs1_busy=0 for rs1_addr=0, and idle is unaffected.
